// File: rtl/rv32_dext_pkg.sv
// rv32_dext_pkg: shared types and defaults for the dext-to-Wishbone bridge.
package rv32_dext_pkg;

    localparam int DEXT_TIMEOUT_DEFAULT = 64;

    typedef struct packed {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } dext_req_t;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } dext_state_e;

endpackage

// File: rtl/rv32_dext_req_buf.sv
// rv32_dext_req_buf: active request slot feeding the bus plus one pending slot behind it.
module rv32_dext_req_buf
    import rv32_dext_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  logic      pop,
    input  dext_req_t push_rec,
    output dext_req_t act_rec,
    output logic      pend_valid,
    output logic      overflow
);

    dext_req_t act_q, act_d, pend_q, pend_d;
    logic      act_v_q, act_v_d, pend_v_q, pend_v_d;

    always_comb begin
        act_d    = act_q;
        act_v_d  = act_v_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        overflow = 1'b0;
        if (pop) begin
            // retiring the active slot: pending advances, a same-cycle push refills behind it
            act_d    = pend_v_q ? pend_q : (push ? push_rec : act_q);
            act_v_d  = pend_v_q || push;
            pend_d   = (pend_v_q && push) ? push_rec : pend_q;
            pend_v_d = pend_v_q && push;
        end else if (push) begin
            if (!act_v_q) begin
                act_d   = push_rec;
                act_v_d = 1'b1;
            end else if (!pend_v_q) begin
                pend_d   = push_rec;
                pend_v_d = 1'b1;
            end else begin
                overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q    <= '0;
            act_v_q  <= 1'b0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            act_q    <= act_d;
            act_v_q  <= act_v_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    assign act_rec    = act_q;
    assign pend_valid = pend_v_q;

endmodule

// File: rtl/rv32_mod_dext_wb_bridge.sv
// rv32_mod_dext_wb_bridge: dext port to Wishbone B4 classic master, one bus cycle in flight plus one pending.
// Build option RV32_DEXT_TIMEOUT_EN forces an error after TIMEOUT_CYCLES silent bus cycles.
module rv32_mod_dext_wb_bridge
    import rv32_dext_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEXT_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dext_req,
    input  logic        dext_wr,
    input  logic [3:0]  dext_be,
    input  logic [31:0] dext_addr,
    input  logic [31:0] dext_do,
    output logic        dext_ack,
    output logic        dext_err,
    output logic [31:0] dext_di,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic        proto_err
);

    dext_state_e state_q, state_d;
    dext_req_t   in_rec, act;
    logic        pend_valid, overflow, tmo, done, err_c;
    logic        ack_q, ack_d, err_q, err_d, proto_q, proto_d;
    logic [31:0] di_q, di_d;

    assign in_rec = '{wr: dext_wr, be: dext_be, addr: dext_addr, data: dext_do};

    rv32_dext_req_buf u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (dext_req),
        .pop        (state_q == RESP),
        .push_rec   (in_rec),
        .act_rec    (act),
        .pend_valid (pend_valid),
        .overflow   (overflow)
    );

`ifdef RV32_DEXT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (state_q == BUS) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign tmo = (state_q == BUS) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_comb begin
        done    = (state_q == BUS) && (wb_ack || wb_err || tmo);
        err_c   = wb_err || (tmo && !wb_ack);
        state_d = (state_q == IDLE) ? (dext_req ? BUS : IDLE) :
                  (state_q == BUS)  ? (done ? RESP : BUS) :
                  ((pend_valid || dext_req) ? BUS : IDLE);
        ack_d   = done && !err_c;
        err_d   = done && err_c;
        di_d    = done ? ((!err_c && !act.wr) ? wb_dat_i : '0) : di_q;
        proto_d = proto_q || overflow;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            di_q    <= '0;
            proto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            di_q    <= di_d;
            proto_q <= proto_d;
        end
    end

    assign wb_cyc    = (state_q == BUS);
    assign wb_stb    = wb_cyc;
    assign wb_we     = act.wr;
    assign wb_sel    = act.be;
    assign wb_adr    = act.addr;
    assign wb_dat_o  = act.data;
    assign dext_ack  = ack_q;
    assign dext_err  = err_q;
    assign dext_di   = di_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_rv32_mod_dext_wb_bridge.sv
// tb_rv32_mod_dext_wb_bridge: directed vector bench for the dext-to-Wishbone bridge.
module tb_rv32_mod_dext_wb_bridge;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic [31:0] rdata;
        int          mode;
        int          lat;
        logic        ack;
        logic        err;
        logic [31:0] di;
        int          cyc;
    } vec_t;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        dext_req = 1'b0, dext_wr = 1'b0;
    logic [3:0]  dext_be = '0;
    logic [31:0] dext_addr = '0, dext_do = '0;
    logic        dext_ack, dext_err;
    logic [31:0] dext_di;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;
    logic        proto_err;

    int          checks = 0, failures = 0;
    logic        s_en = 1'b0, s_force = 1'b0;
    int          s_waits = 0, s_mode = 0, s_cnt = 0;
    logic [31:0] s_rdata = '0;
    vec_t        tbl [7];

    always #5 clk = ~clk;

    rv32_mod_dext_wb_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dext_req  (dext_req),
        .dext_wr   (dext_wr),
        .dext_be   (dext_be),
        .dext_addr (dext_addr),
        .dext_do   (dext_do),
        .dext_ack  (dext_ack),
        .dext_err  (dext_err),
        .dext_di   (dext_di),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .proto_err (proto_err)
    );

    // slave model: responds after s_waits wait states; mode 0=ack 1=err 2=both
    always @(negedge clk) begin
        if (!s_en) begin
            wb_ack = s_force;
            wb_err = 1'b0;
            s_cnt  = 0;
        end else if (wb_cyc) begin
            wb_ack   = (s_cnt == s_waits) && (s_mode != 1);
            wb_err   = (s_cnt == s_waits) && (s_mode != 0);
            wb_dat_i = s_rdata;
            s_cnt++;
        end else begin
            wb_ack = 1'b0;
            wb_err = 1'b0;
            s_cnt  = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        dext_req  = 1'b1;
        dext_wr   = wr;
        dext_be   = be;
        dext_addr = addr;
        dext_do   = data;
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int          lat = 0, cyc = 0;
        logic        ack = 1'b0, err = 1'b0, bus_bad = 1'b0;
        logic [31:0] di = '0;
        s_waits = v.waits;
        s_mode  = v.mode;
        s_rdata = v.rdata;
        issue(v.wr, v.be, v.addr, v.data);
        for (int n = 1; n <= 30 && lat == 0; n++) begin
            @(negedge clk);
            dext_req = 1'b0;
            if (wb_cyc) begin
                cyc++;
                if (!wb_stb || wb_we !== v.wr || wb_sel !== v.be || wb_adr !== v.addr || wb_dat_o !== v.data)
                    bus_bad = 1'b1;
            end
            if (dext_ack || dext_err) begin
                lat = n;
                ack = dext_ack;
                err = dext_err;
                di  = dext_di;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_ack", idx), {31'd0, ack}, {31'd0, v.ack});
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.err});
        chk($sformatf("v%0d_di", idx), di, v.di);
        chk($sformatf("v%0d_cyc_cycles", idx), 32'(cyc), 32'(v.cyc));
        chk($sformatf("v%0d_bus_fields_bad", idx), {31'd0, bus_bad}, 32'd0);
        chk($sformatf("v%0d_pulse_end", idx), {30'd0, dext_ack, dext_err}, 32'd0);
    endtask

    // requests at consecutive cycles, slave with 2 wait states; third one (if any) must be dropped
    task automatic do_multi(input int nreq, input logic exp_proto, input string tag);
        int          acks = 0, rises = 0, hi = 0, a1 = 0, a2 = 0;
        logic        prev = 1'b0, we2 = 1'b0;
        logic [31:0] di1 = '1, di2 = '1, adr2 = '0;
        s_waits = 2;
        s_mode  = 0;
        s_rdata = 32'h600D_F00D;
        for (int n = 0; n <= 14; n++) begin
            @(negedge clk);
            if (n > 0) begin
                if (wb_cyc && !prev) begin
                    rises++;
                    if (rises == 2) begin
                        adr2 = wb_adr;
                        we2  = wb_we;
                    end
                end
                if (wb_cyc) hi++;
                prev = wb_cyc;
                if (dext_ack) begin
                    acks++;
                    if (acks == 1) begin
                        a1  = n;
                        di1 = dext_di;
                    end else begin
                        a2  = n;
                        di2 = dext_di;
                    end
                end
            end
            dext_req  = (n < nreq);
            dext_wr   = 1'(n & 1);
            dext_be   = 4'hF;
            dext_addr = 32'(16 * (n + 1));
            dext_do   = 32'(160 + n);
        end
        chk({tag, "_acks"}, 32'(acks), 32'd2);
        chk({tag, "_ack1_cycle"}, 32'(a1), 32'd4);
        chk({tag, "_ack2_cycle"}, 32'(a2), 32'd8);
        chk({tag, "_bus_cycles"}, 32'(rises), 32'd2);
        chk({tag, "_cyc_high"}, 32'(hi), 32'd6);
        chk({tag, "_di1"}, di1, 32'h600D_F00D);
        chk({tag, "_di2"}, di2, 32'd0);
        chk({tag, "_adr2"}, adr2, 32'h20);
        chk({tag, "_we2"}, {31'd0, we2}, 32'd1);
        chk({tag, "_proto_err"}, {31'd0, proto_err}, {31'd0, exp_proto});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int   hi;
        int   resp;
        vec_t tv;
        tbl[0] = '{1'b0, 4'hF, 32'h100,      32'h0,        0, 32'hDEADBEEF, 0, 2, 1'b1, 1'b0, 32'hDEADBEEF, 1};
        tbl[1] = '{1'b0, 4'hF, 32'h404,      32'h0,        0, 32'h11112222, 2, 2, 1'b0, 1'b1, 32'h0,        1};
        tbl[2] = '{1'b0, 4'h1, 32'h8,        32'h0,        2, 32'hA5A5A5A5, 0, 4, 1'b1, 1'b0, 32'hA5A5A5A5, 3};
        tbl[3] = '{1'b0, 4'h3, 32'h300,      32'h0,        1, 32'hCAFEF00D, 1, 3, 1'b0, 1'b1, 32'h0,        2};
        tbl[4] = '{1'b0, 4'hF, 32'h40C,      32'h0,        0, 32'h11112222, 0, 2, 1'b1, 1'b0, 32'h11112222, 1};
        tbl[5] = '{1'b1, 4'hC, 32'h204,      32'h12345678, 3, 32'hFFFFFFFF, 0, 5, 1'b1, 1'b0, 32'h0,        4};
        tbl[6] = '{1'b1, 4'hF, 32'hFFFFFFFC, 32'h89ABCDEF, 0, 32'h0,        0, 2, 1'b1, 1'b0, 32'h0,        1};

        s_force  = 1'b1;
        dext_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_flags", {26'd0, dext_ack, dext_err, wb_cyc, wb_stb, wb_we, proto_err}, 32'd0);
        chk("rst_sel", {28'd0, wb_sel}, 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat_o", wb_dat_o, 32'd0);
        chk("rst_di", dext_di, 32'd0);
        dext_req = 1'b0;
        s_force  = 1'b0;
        s_en     = 1'b1;
        reset_n  = 1'b1;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(wb_cyc);
        end
        chk("idle_cyc_high", 32'(hi), 32'd0);

        for (int i = 0; i < 7; i++) do_txn(tbl[i], i);

        do_multi(2, 1'b0, "pending");
        do_multi(3, 1'b1, "overflow");

`ifdef RV32_DEXT_TIMEOUT_EN
        tv = '{1'b0, 4'hF, 32'h600, 32'h0, 1000, 32'h0, 0, 9, 1'b0, 1'b1, 32'h0, 8};
        do_txn(tv, 90);
        s_waits = 1000;
        issue(1'b0, 4'hF, 32'h500, 32'h0);
        @(negedge clk);
        dext_req = 1'b0;
        repeat (2) @(negedge clk);
`else
        tv = tbl[0];
        s_waits = 1000;
        issue(tv.wr, 4'hF, 32'h500, 32'h0);
        hi   = 0;
        resp = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            dext_req = 1'b0;
            hi   += int'(wb_cyc);
            resp += int'(dext_ack || dext_err);
        end
        chk("silent_no_resp", 32'(resp), 32'd0);
        chk("silent_cyc_high", 32'(hi), 32'd20);
`endif
        chk("pre_rst_cyc", {31'd0, wb_cyc}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("midrst_proto", {31'd0, proto_err}, 32'd0);
        chk("midrst_resp", {30'd0, dext_ack, dext_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_txn(tbl[0], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_mod_dext_wb_bridge.md
# rv32_mod_dext_wb_bridge

Bridges the load/store unit's external data port (dext_*) to a Wishbone B4 classic master port. It sits directly downstream of the load/store unit, between the hart and the system data bus. It registers each one-cycle dext request, runs one bus cycle at a time, and holds one further request in a pending slot. Completion is returned as a one-cycle dext_ack or dext_err pulse.

## Interface
- TIMEOUT_CYCLES, 64: wait-cycle limit before forced error (≥2); used only with the timeout build option
- clk  in  1  clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- dext_req  in  1  one-cycle request pulse from the load/store unit
- dext_wr  in  1  1 = store
- dext_be  in  4  byte enables
- dext_addr  in  32  word-aligned address; bits [1:0] are forwarded unchanged
- dext_do  in  32  store data
- dext_ack  out  1  one-cycle completion pulse
- dext_err  out  1  one-cycle error pulse
- dext_di  out  32  load data; valid while dext_ack=1
- wb_cyc, wb_stb  out  1  bus cycle and strobe, always equal
- wb_we  out  1  write enable
- wb_sel  out  4  byte select (= dext_be)
- wb_adr  out  32  address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack  in  1  slave acknowledge
- wb_err  in  1  slave error
- proto_err  out  1  sticky flag: request dropped on overflow

## Operation
- Request record: {wr, be, addr, data}, 69 bits. One active slot feeds the bus. One pending slot buffers a request that arrives while the bridge is busy.
- FSM states: IDLE, BUS, RESP.
  - IDLE, dext_req=1: latch the request into the active slot, go to BUS.
  - BUS: wb_cyc=wb_stb=1, and the wb_* outputs come from the active slot. On wb_ack or wb_err, go to RESP. If both are high in the same cycle, err wins.
  - RESP: dext_ack or dext_err is high for exactly this cycle, and wb_cyc=0. Next state is BUS (pending slot moves to active) if pending is valid, otherwise IDLE.
- dext_req=1 in BUS or RESP:
  - Pending empty: write the request into pending.
  - In RESP with pending valid: pending moves to active and the new request fills pending in the same edge.
  - In BUS with pending valid: drop the request and set proto_err. proto_err clears only on reset.
- dext_di:
  - On a read ack, load wb_dat_i.
  - On a write ack or any error, load 0.
  - Otherwise hold its value.

## Timing
- Reset values: every output is 0, FSM is IDLE, both slots are invalid.
- dext_req sampled at edge 0 → wb_cyc=1 from edge 0 to edge k, where k is the first edge with wb_ack or wb_err high.
- RESP occupies the cycle after edge k.
- Zero-wait slave: dext_ack is high 2 cycles after dext_req. Each slave wait state adds 1 cycle.
- Back-to-back requests: wb_cyc is low for exactly one cycle (the RESP cycle) between transactions.
- The wb_* outputs are registered and stay stable for the whole BUS state. wb_ack/wb_err are ignored outside BUS.
- If reset_n is asserted mid-transfer, wb_cyc drops immediately and the transaction is abandoned without a response. The slave must tolerate this.

## Configuration
- RV32_DEXT_TIMEOUT_EN defined:
  - A wait counter, width $clog2(TIMEOUT_CYCLES), clears on entering BUS and increments each BUS cycle that has no wb_ack/wb_err.
  - At the edge where count == TIMEOUT_CYCLES-1 with no ack or err, the FSM goes to RESP with dext_err=1 and dext_di=0.
  - Counting starts at the edge that enters BUS (edge 0 in the Timing section, count=0 after it). The forced error therefore fires at edge TIMEOUT_CYCLES when no ack or err arrives.
- Not defined: no counter is built, and BUS waits indefinitely.

## Structure
- Package rv32_dext_pkg:
  - dext_req_t, the packed request record
  - dext_state_e enum {IDLE, BUS, RESP}
  - DEXT_TIMEOUT_DEFAULT = 64
- Sub-module rv32_dext_req_buf holds both slots:
  - Inputs: push, pop, push-record.
  - Outputs: active record, pending_valid, overflow.
  - The main module keeps the FSM, the timeout counter and the output registers.

## Test plan
- Reset: hold reset_n=0 while driving wb_ack=1 → every output is 0. After release with no request, wb_cyc stays 0 for 10 cycles.
- Zero-wait read: read at addr 0x100 with be=4'hF. Slave acks on the first wb_cyc cycle with wb_dat_i=0xDEADBEEF → dext_ack=1 and dext_di=0xDEADBEEF exactly 2 cycles after dext_req. wb_cyc is high for 1 cycle.
- Write with waits: write at addr 0x204, be=4'b1100, data 0x12345678. Slave acks after 3 wait states → wb_we=1, wb_sel=4'b1100, wb_dat_o=0x12345678 for 4 cycles. dext_ack is high 5 cycles after dext_req, with dext_di=0.
- Pending: send a second request 1 cycle after the first, with a slave at 2 wait states → the second bus cycle starts after exactly one wb_cyc-low cycle. Two dext_ack pulses appear, in order, and proto_err=0.
- Overflow: send a third dext_req while in BUS with pending full → proto_err=1 and only 2 bus cycles occur.
- Error handling:
  - wb_ack and wb_err high in the same cycle → dext_err=1, dext_ack=0, dext_di=0.
  - With RV32_DEXT_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, a silent slave → dext_err pulse 9 cycles after dext_req.
